// File: rtl/br_amba_apb_timing_slice_fsm.sv
// APB4 timing slice: registers every signal between an upstream APB manager
// and a downstream APB target, with an optional access timeout.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   p*_in  (upstream side)   paddr, psel, penable, pprot, pstrb, pwrite, pwdata
//   prdata_out, pready_out,  upstream response, one-cycle pready_out pulse
//   pslverr_out
//   p*_out (downstream side) registered request toward the target
//   prdata_in, pready_in,    downstream response
//   pslverr_in
//   timeout_out              one-cycle pulse when an access is aborted
package br_amba;
    localparam int ApbProtWidth = 3;
endpackage

module br_amba_apb_timing_slice_fsm #(
    parameter int AddrWidth     = 12,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 0,
    localparam int StrbWidth    = DataWidth / 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [AddrWidth-1:0]            paddr_in,
    input  logic                            psel_in,
    input  logic                            penable_in,
    input  logic [br_amba::ApbProtWidth-1:0] pprot_in,
    input  logic [StrbWidth-1:0]            pstrb_in,
    input  logic                            pwrite_in,
    input  logic [DataWidth-1:0]            pwdata_in,
    output logic [DataWidth-1:0]            prdata_out,
    output logic                            pready_out,
    output logic                            pslverr_out,
    output logic [AddrWidth-1:0]            paddr_out,
    output logic                            psel_out,
    output logic                            penable_out,
    output logic [br_amba::ApbProtWidth-1:0] pprot_out,
    output logic [StrbWidth-1:0]            pstrb_out,
    output logic                            pwrite_out,
    output logic [DataWidth-1:0]            pwdata_out,
    input  logic [DataWidth-1:0]            prdata_in,
    input  logic                            pready_in,
    input  logic                            pslverr_in,
    output logic                            timeout_out
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StSetup  = 2'd1;
    localparam logic [1:0] StAccess = 2'd2;
    localparam logic [1:0] StResp   = 2'd3;

    // Counter keeps a 1-bit width when the timeout is disabled so that
    // the declaration stays legal; it is then never compared as true.
    localparam int CntWidth =
        (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam int TimeoutLast =
        (TimeoutCycles > 0) ? TimeoutCycles - 1 : 0;

    if (AddrWidth < 12) begin : g_bad_addr
        $error("AddrWidth must be >= 12");
    end
    if (DataWidth != 8 && DataWidth != 16 && DataWidth != 32) begin : g_bad_data
        $error("DataWidth must be 8, 16 or 32");
    end

    logic [1:0]          state;
    logic [CntWidth-1:0] wait_cnt;
    logic                timeout_hit;

    // wait_cnt holds the number of already-elapsed waited ACCESS cycles, so
    // the current cycle is the last allowed one when it equals TimeoutLast.
    // A ready in that same cycle still completes normally.
    assign timeout_hit = (TimeoutCycles > 0) && !pready_in &&
                         (wait_cnt == CntWidth'(TimeoutLast));

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= StIdle;
            wait_cnt    <= '0;
            paddr_out   <= '0;
            psel_out    <= 1'b0;
            penable_out <= 1'b0;
            pprot_out   <= '0;
            pstrb_out   <= '0;
            pwrite_out  <= 1'b0;
            pwdata_out  <= '0;
            prdata_out  <= '0;
            pready_out  <= 1'b0;
            pslverr_out <= 1'b0;
            timeout_out <= 1'b0;
        end else begin
            timeout_out <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (psel_in) begin
                        paddr_out  <= paddr_in;
                        pprot_out  <= pprot_in;
                        pstrb_out  <= pstrb_in;
                        pwrite_out <= pwrite_in;
                        pwdata_out <= pwdata_in;
                        psel_out   <= 1'b1;
                        wait_cnt   <= '0;
                        state      <= StSetup;
                    end
                end
                StSetup: begin
                    penable_out <= 1'b1;
                    state       <= StAccess;
                end
                StAccess: begin
                    if (pready_in) begin
                        psel_out    <= 1'b0;
                        penable_out <= 1'b0;
                        pslverr_out <= pslverr_in;
                        if (!pwrite_out) begin
                            prdata_out <= prdata_in;
                        end
                        pready_out  <= 1'b1;
                        state       <= StResp;
                    end else if (timeout_hit) begin
                        // Abandon the hung target and report an error upstream.
                        psel_out    <= 1'b0;
                        penable_out <= 1'b0;
                        pslverr_out <= 1'b1;
                        prdata_out  <= '0;
                        pready_out  <= 1'b1;
                        timeout_out <= 1'b1;
                        state       <= StResp;
                    end else begin
                        wait_cnt <= wait_cnt + CntWidth'(1);
                    end
                end
                StResp: begin
                    pready_out  <= 1'b0;
                    pslverr_out <= 1'b0;
                    state       <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    a_penable_needs_psel: assert property (
        @(posedge clk) disable iff (rst)
        penable_in |-> psel_in
    );

    a_psel_held: assert property (
        @(posedge clk) disable iff (rst)
        (psel_in && !pready_out) |=> psel_in
    );

    a_inputs_stable: assert property (
        @(posedge clk) disable iff (rst)
        (psel_in && !pready_out) |=>
        (!psel_in || $stable({paddr_in, pprot_in, pstrb_in, pwrite_in, pwdata_in}))
    );

endmodule
